// File: rtl/tx_frame_pkg.sv
// tx_frame_pkg: frame state encoding, PN taps and frame timing defaults shared by the Tx generator
// and the Rx SOP detector.
package tx_frame_pkg;
  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GAP} state_t;
  localparam logic [14:0] PN_TAPS = 15'h6000;
  localparam int FRAME_LEN_DEF = 52800;
  localparam int PRE_LEN_DEF = 256;
  localparam int PAY_LEN_DEF = 4096;
  localparam int N_SOP_OPOR = 20;
endpackage

// File: rtl/tx_pn_gen.sv
// tx_pn_gen: 15-bit Fibonacci LFSR, MSB out, tap parity shifted in at the LSB.
module tx_pn_gen
  import tx_frame_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [14:0] seed,
  output logic        bit_out
);
  logic [14:0] lfsr;
  always_ff @(posedge clk)
    if (rst || load) lfsr <= seed;
    else if (step) lfsr <= {lfsr[13:0], ^(lfsr & PN_TAPS)};
  assign bit_out = lfsr[14];
endmodule

// File: rtl/tx_frame_gen.sv
// tx_frame_gen: periodic Tx frame generator: PN preamble, ready/valid payload, zero gap.
module tx_frame_gen
  import tx_frame_pkg::*;
#(
  parameter int DW = 16,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int PRE_LEN = PRE_LEN_DEF,
  parameter int PAY_LEN = PAY_LEN_DEF,
  parameter logic [14:0] PN_SEED = 15'h7FFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] amp,
  input  logic [2*DW-1:0] pay_data,
  input  logic          pay_valid,
  output logic          pay_ready,
  output logic [DW-1:0] tx_i,
  output logic [DW-1:0] tx_q,
  output logic          tx_valid,
  output logic          tx_sop,
  output logic          tx_eop,
  output logic [15:0]   frame_cnt,
  output logic [15:0]   underrun_cnt
);
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] PRE_END = CW'(PRE_LEN - 1);
  localparam logic [CW-1:0] PAY_END = CW'(PRE_LEN + PAY_LEN - 1);
  localparam logic [CW-1:0] GAP_END = CW'(FRAME_LEN - 1);
  localparam logic [DW-1:0] AMP_BAD = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] AMP_MAX = {1'b0, {(DW-1){1'b1}}};
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] amp_r;
  logic pn_bit, pre, sop, xfer, frame_end, start;
  assign pre = state == PREAMBLE;
  assign sop = pre && cnt == '0;
  assign pay_ready = state == PAYLOAD;
  assign xfer = pay_ready && pay_valid;
  assign frame_end = state == GAP && cnt == GAP_END;
  assign start = en && (state == IDLE || frame_end);
  tx_pn_gen u_pn (
    .clk(clk),
    .rst(rst),
    .load(start),
    .step(pre),
    .seed(PN_SEED),
    .bit_out(pn_bit)
  );
  always_comb begin
    state_n = state;
    cnt_n = (state == IDLE || frame_end) ? '0 : cnt + 1'b1;
    if (start) state_n = PREAMBLE;
    else if (frame_end) state_n = IDLE;
    else if (pre && cnt == PRE_END) state_n = PAYLOAD;
    else if (pay_ready && cnt == PAY_END) state_n = GAP;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      amp_r <= '0;
      tx_i <= '0;
      tx_q <= '0;
      tx_valid <= 1'b0;
      tx_sop <= 1'b0;
      tx_eop <= 1'b0;
      frame_cnt <= '0;
      underrun_cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (start) amp_r <= amp == AMP_BAD ? AMP_MAX : amp;
      tx_valid <= state != IDLE;
      tx_sop <= sop;
      tx_eop <= pay_ready && cnt == PAY_END;
      tx_i <= pre ? (pn_bit ? amp_r : -amp_r) : xfer ? pay_data[2*DW-1:DW] : '0;
      tx_q <= xfer ? pay_data[DW-1:0] : '0;
      frame_cnt <= frame_cnt + {15'd0, sop};
      if (pay_ready && !pay_valid && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 1'b1;
    end
endmodule

// File: tb/tb_tx_frame_gen.sv
// tb_tx_frame_gen: directed checks of frame timing, PN preamble, payload handshake and counters.
module tb_tx_frame_gen;
  localparam int FL = 400;
  localparam int PL = 32;
  localparam int YL = 64;
  logic clk = 1'b0;
  logic rst = 1'b1, rst2 = 1'b1, en = 1'b0, pay_valid = 1'b0, pay_ready;
  logic [15:0] amp = 16'd0, tx_i, tx_q, frame_cnt, underrun_cnt;
  logic [31:0] pay_data = 32'h0000A5A5;
  logic tx_valid, tx_sop, tx_eop;
  logic s_ready, s_valid, s_sop, s_eop;
  logic [15:0] s_i, s_q, s_fc, s_uc;
  logic [15:0] ramp = 16'd0, exp_r = 16'd0, fexp = 16'd0, uexp = 16'd0;
  int total = 0, bad = 0, cyc = 0, c0 = 0;
  bit pn [0:PL-1];

  always #5 clk = ~clk;

  tx_frame_gen #(.DW(16), .FRAME_LEN(FL), .PRE_LEN(PL), .PAY_LEN(YL)) dut (
    .clk(clk), .rst(rst), .en(en), .amp(amp), .pay_data(pay_data), .pay_valid(pay_valid),
    .pay_ready(pay_ready), .tx_i(tx_i), .tx_q(tx_q), .tx_valid(tx_valid), .tx_sop(tx_sop),
    .tx_eop(tx_eop), .frame_cnt(frame_cnt), .underrun_cnt(underrun_cnt)
  );

  // Long payload, source never valid: drives underrun_cnt into saturation.
  tx_frame_gen #(.DW(16), .FRAME_LEN(32773), .PRE_LEN(4), .PAY_LEN(32768)) sat (
    .clk(clk), .rst(rst2), .en(1'b1), .amp(16'd0), .pay_data(32'd0), .pay_valid(1'b0),
    .pay_ready(s_ready), .tx_i(s_i), .tx_q(s_q), .tx_valid(s_valid), .tx_sop(s_sop),
    .tx_eop(s_eop), .frame_cnt(s_fc), .underrun_cnt(s_uc)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic x;
    x = pay_ready && pay_valid;
    @(posedge clk);
    #1;
    cyc++;
    if (x) ramp++;
    pay_data = {ramp, ramp ^ 16'hA5A5};
  endtask

  task automatic wait_sop(input int lat);
    int n;
    n = 0;
    while (!tx_sop && n < 50) begin
      tick();
      n++;
    end
    chk("sop_lat", n, lat);
  endtask

  // Entered on the tx_sop sample; leaves on the sample one frame period later.
  task automatic run_frame(input logic [15:0] a, input logic [15:0] a_next, input int lo_at,
                           input int lo_n, input int drop_at);
    logic v;
    logic [15:0] xi, xq;
    int j, jn;
    fexp++;
    chk("frame_cnt", frame_cnt, fexp);
    amp = a_next;
    v = 1'b1;
    for (int p = 0; p < FL; p++) begin
      j = p - PL;
      xi = 16'd0;
      xq = 16'd0;
      if (p < PL) xi = pn[p] ? a : -a;
      else if (j < YL && v) begin
        xi = exp_r;
        xq = exp_r ^ 16'hA5A5;
        exp_r++;
      end else if (j < YL) uexp++;
      chk($sformatf("smp%0d", p), {tx_valid, tx_sop, tx_eop, pay_ready, tx_i, tx_q},
          {1'b1, p == 0, j == YL - 1, (p + 1 >= PL) && (p + 1 < PL + YL), xi, xq});
      if (p == FL - 1) chk("underrun", underrun_cnt, uexp);
      jn = p + 1 - PL;
      v = !(jn >= lo_at && jn < lo_at + lo_n);
      pay_valid = v;
      if (p == drop_at) en = 1'b0;
      tick();
    end
  endtask

  initial begin
    for (int n = 0; n < PL; n++) pn[n] = (n < 15) ? 1'b1 : pn[n-15] ^ pn[n-14];
    repeat (3) tick();
    rst = 1'b0;
    rst2 = 1'b0;
    c0 = cyc;
    chk("rst_out", {tx_valid, tx_sop, tx_eop, pay_ready, tx_i, tx_q}, 0);
    chk("rst_fc", frame_cnt, 0);
    chk("rst_uc", underrun_cnt, 0);
    chk("rst_sat_uc", s_uc, 0);
    tick();
    chk("idle_out", {tx_valid, tx_sop, tx_i}, 0);
    amp = 16'd1000;
    pay_valid = 1'b1;
    en = 1'b1;
    wait_sop(2);
    for (int f = 0; f < 21; f++) run_frame(16'd1000, 16'd1000, 0, 0, -1);
    run_frame(16'd1000, 16'h8000, 5, 10, -1);
    run_frame(16'h7FFF, 16'd500, 0, 0, PL + 40);
    chk("drop_idle", {tx_valid, tx_sop, pay_ready}, 0);
    repeat (3) tick();
    chk("drop_idle2", {tx_valid, tx_sop, tx_i}, 0);
    en = 1'b1;
    wait_sop(2);
    run_frame(16'd500, 16'd500, 0, 0, -1);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_out", {tx_valid, tx_sop, tx_eop, pay_ready, tx_i, tx_q}, 0);
    chk("mid_rst_fc", frame_cnt, 0);
    chk("mid_rst_uc", underrun_cnt, 0);
    fexp = 16'd0;
    uexp = 16'd0;
    wait_sop(2);
    run_frame(16'd500, 16'd500, 3, 1, -1);
    while (cyc < c0 + 32775) tick();
    chk("sat_frame1", s_uc, 16'd32768);
    while (cyc < c0 + 65544) tick();
    chk("sat_fffe", s_uc, 16'hFFFE);
    while (cyc < c0 + 65700) tick();
    chk("sat_ffff", s_uc, 16'hFFFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tx_frame_gen.md
Name: tx_frame_gen

Overview:
- Transmit-side frame timing generator; the counterpart of the Rx SOP detector and auto-threshold logic.
- Emits one frame every FRAME_LEN samples: PN preamble, then PAY_LEN payload samples pulled from upstream by ready/valid, then zero gap.
- Drives the DAC/upconverter sample stream and a tx_sop strobe. The receiver's xcorr detects this preamble and expects 20 SOPs per 20*FRAME_LEN-sample window.

Parameters:
- DW, 16, bit width of each of I and Q.
- FRAME_LEN, 52800, samples per frame period. Constraint: FRAME_LEN >= PRE_LEN + PAY_LEN + 1.
- PRE_LEN, 256, preamble length in samples.
- PAY_LEN, 4096, payload length in samples.
- PN_SEED, 15'h7FFF, LFSR seed; must be nonzero.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- en  in  1  frame generation enable
- amp  in  DW  preamble amplitude, unsigned, sampled at each SOP
- pay_data  in  2*DW  payload sample {I,Q}, two's complement
- pay_valid  in  1  payload sample available
- pay_ready  out  1  block accepts payload this cycle
- tx_i  out  DW  output I sample
- tx_q  out  DW  output Q sample
- tx_valid  out  1  output sample valid
- tx_sop  out  1  one-cycle pulse coincident with the first preamble sample
- tx_eop  out  1  one-cycle pulse coincident with the last payload sample
- frame_cnt  out  16  frames started since reset, wraps
- underrun_cnt  out  16  payload samples replaced by zero, saturating at 16'hFFFF

Behaviour:
- Reset values: tx_i, tx_q, tx_valid, tx_sop, tx_eop, pay_ready, frame_cnt, underrun_cnt all 0. State is IDLE, sample counter is 0, LFSR = PN_SEED.
- States and transitions:
  - IDLE -> PREAMBLE when en=1.
  - PREAMBLE lasts PRE_LEN cycles, then PAYLOAD.
  - PAYLOAD lasts PAY_LEN cycles, then GAP.
  - GAP runs until the sample counter reaches FRAME_LEN-1. From GAP go to PREAMBLE if en=1, else IDLE.
- en is evaluated only in IDLE and at the GAP-to-next-frame boundary. Deasserting en mid-frame completes the current frame.
- Sample counter 0..FRAME_LEN-1 runs only outside IDLE and wraps to 0 at frame start. This gives an exact period of FRAME_LEN cycles between tx_sop pulses while en stays 1.
- All outputs are registered; each output sample appears 1 cycle after its state/counter value.
- tx_valid = 1 in every non-IDLE cycle, including GAP, where tx_i = tx_q = 0.
- Preamble generation:
  - At frame start, reload LFSR = PN_SEED and latch amp.
  - Each PREAMBLE cycle: output bit b = lfsr[14]; next lfsr = {lfsr[13:0], lfsr[14]^lfsr[13]}.
  - tx_i = b ? +amp : -amp (two's complement negation in DW bits); tx_q = 0.
  - amp = 2^(DW-1) is invalid; clamp it to 2^(DW-1)-1.
- Payload handshake:
  - pay_ready = 1 combinationally in every PAYLOAD-state cycle, 0 otherwise. A transfer occurs when pay_ready & pay_valid.
  - Transfer: tx_i/tx_q = pay_data fields.
  - No transfer in a PAYLOAD cycle: output 0 and increment underrun_cnt (saturating). Payload timing never stalls.
  - pay_valid outside PAYLOAD is ignored.
- tx_sop: asserted with the output of PREAMBLE cycle 0. frame_cnt increments in the same cycle.
- tx_eop: asserted with the output of PAYLOAD cycle PAY_LEN-1.
- rst mid-frame returns to the reset state next cycle. No partial frame resumes.

Decomposition:
- Package tx_frame_pkg:
  - state enum {IDLE, PREAMBLE, PAYLOAD, GAP}
  - constant PN_TAPS
  - default FRAME_LEN/PRE_LEN/PAY_LEN localparams shared with the Rx detector (e.g. n_sop_opor = 20)
- Sub-module tx_pn_gen: 15-bit LFSR with ports load, step, seed, bit_out.

Test Plan:
- Reset then en=1, amp=1000: tx_sop at first valid output. Preamble samples 0..14 = +1000, sample 15 = -1000, tx_q = 0 throughout.
- en held 1, pay_valid always 1: tx_sop spacing exactly 52800 cycles over 21 frames. frame_cnt = 21. underrun_cnt = 0. tx_eop 4095 output samples after the first payload sample.
- Payload source ramp with pay_valid low for 10 cycles inside PAYLOAD: exactly 10 zero samples output, underrun_cnt = 10, following payload values continue the ramp without loss.
- en dropped at PAYLOAD cycle 100: frame completes through GAP, then IDLE with tx_valid = 0. en reasserted: new tx_sop 1 cycle after IDLE exit, LFSR restarted (first 15 samples +amp).
- rst pulsed at PREAMBLE cycle 50: next cycle all outputs 0, frame_cnt = 0. Restart replays the preamble from PN_SEED.
- amp = 16'h8000: preamble values clamp to +/-32767. underrun_cnt forced near 16'hFFFE saturates at 16'hFFFF.
